// File: rtl/stream_demux_1x2_64bit_pkg.sv
// Shared defaults and slot state encoding for the 1-to-2 registered stream demux.
package stream_demux_1x2_64bit_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int CNT_W_DEF = 16;
  localparam int NUM_OUTS  = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/stream_demux_1x2_64bit_demux_slot.sv
// One output register stage: load, drain, same-cycle replace, and a delivery counter.
module demux_slot
  import stream_demux_1x2_64bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] cnt
);
  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;

  assign xfer = (state_q == SLOT_FULL) && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // A load wins over a drain so a simultaneous transfer+load leaves no bubble.
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (xfer) begin
      state_d = SLOT_EMPTY;
    end
    if (xfer) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign cnt       = cnt_q;
endmodule

// File: rtl/stream_demux_1x2_64bit.sv
// Registered 1-to-2 valid/ready demux; each output owns one slot so consumers stall independently.
module stream_demux_1x2_64bit
  import stream_demux_1x2_64bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic [NUM_OUTS-1:0]            slot_valid;
  logic [NUM_OUTS-1:0]            slot_ready;
  logic [NUM_OUTS-1:0]            slot_load;
  logic [NUM_OUTS-1:0][WIDTH-1:0] slot_data;
  logic [NUM_OUTS-1:0][CNT_W-1:0] slot_cnt;
  logic                           accept;

  assign slot_ready = {out1_ready, out0_ready};

  // Ready follows only the selected slot: it can take a word if empty or draining now.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) in_ready = !slot_valid[in_sel] || slot_ready[in_sel];
  end

  assign accept = in_valid && in_ready;

  for (genvar k = 0; k < NUM_OUTS; k++) begin : g_slot
    assign slot_load[k] = accept && (in_sel == 1'(k));

    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (slot_load[k]),
      .load_data (in_data),
      .out_ready (slot_ready[k]),
      .out_valid (slot_valid[k]),
      .out_data  (slot_data[k]),
      .cnt       (slot_cnt[k])
    );
  end

  assign out0_valid = slot_valid[0];
  assign out1_valid = slot_valid[1];
  assign out0_data  = slot_data[0];
  assign out1_data  = slot_data[1];
  assign cnt0       = slot_cnt[0];
  assign cnt1       = slot_cnt[1];
endmodule

// File: doc/stream_demux_1x2_64bit.md
Name: stream_demux_1x2_64bit

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the inverse of the 2:1 datapath mux.
- Steers one 64-bit producer stream to one of two consumers, for example a result bus split to the writeback and forwarding paths.
- Each output has a single registered slot, so the two consumers stall independently.
- Per-output delivery counters support debug and bench checking.

Parameters:
- WIDTH, 64, data width of input and both outputs.
- CNT_W, 16, width of the per-output delivery counters.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has data.
- in_ready  out  1  demux accepts this cycle.
- in_data  in  WIDTH  producer data.
- in_sel  in  1  destination: 0 routes to out0, 1 routes to out1.
- out0_valid  out  1  slot 0 holds data.
- out0_ready  in  1  consumer 0 takes data.
- out0_data  out  WIDTH  slot 0 data.
- out1_valid  out  1  slot 1 holds data.
- out1_ready  in  1  consumer 1 takes data.
- out1_data  out  WIDTH  slot 1 data.
- cnt0  out  CNT_W  words delivered on out0.
- cnt1  out  CNT_W  words delivered on out1.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising clk edge; the reset-port polarity and synchronicity are fixed.
- Reset values: out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0. in_ready is forced to 0 while reset=1.
- Reset mid-operation: pending slot contents are dropped; no output handshake completes on the reset edge.
- Handshakes:
  - Input accept = in_valid && in_ready at a rising edge.
  - Output k transfer = outk_valid && outk_ready at a rising edge.
- in_ready, combinational:
  - in_sel=0: in_ready = !out0_valid || out0_ready.
  - in_sel=1: in_ready = !out1_valid || out1_ready.
  - The combinational ready-to-ready path is intentional.
- Slot k has two states, EMPTY (valid=0) and FULL (valid=1):
  - EMPTY -> FULL on an accept with in_sel==k; data is loaded from in_data.
  - FULL -> EMPTY on an output-k transfer with no simultaneous load into slot k.
  - FULL -> FULL on a simultaneous transfer and load: data is replaced by in_data and valid stays 1. There is no bubble, and full throughput is 1 word/cycle per output.
  - FULL with no transfer: data and valid hold.
- The non-selected slot is never affected by an accept.
- Latency: an accepted word appears on outk_data/outk_valid one cycle after the accept edge.
- Producer rules:
  - The producer holds in_data and in_sel stable while in_valid && !in_ready.
  - The demux does not depend on this for correctness; it only ever samples at an accept.
  - in_valid may deassert at any time.
- Output stability: outk_data is stable while outk_valid && !outk_ready.
- Ordering: per-output order is preserved. No ordering is guaranteed between out0 and out1.
- Counters:
  - cntk increments by 1 on each output-k transfer and wraps modulo 2^CNT_W.
  - Transfers on both outputs in the same cycle increment both counters.
- Reset has priority over every other event on the same edge.

Decomposition:
- Shared package holds the WIDTH default (64), the CNT_W default (16), and the slot state encoding SLOT_EMPTY=1'b0, SLOT_FULL=1'b1.
- Sub-module demux_slot covers one output register stage: load, drain, simultaneous replace, and its counter.
- Top level instantiates demux_slot twice and generates in_ready and the load enables.

Test Plan:
- Reset with in_valid=1, in_data=11 -> in_ready=0, both valids 0, both data 0, cnt0=cnt1=0. Hold reset 2 cycles; after release in_ready=1.
- Accept in_sel=0, in_data=11, then in_sel=1, in_data=22, both readys=1 -> out0_data=11 one cycle after the first accept; out1_data=22 one cycle after the second; cnt0=1, cnt1=1.
- out0_ready=0, send 33 to out0, then attempt 44 to out0 -> 33 is held and in_ready=0 for the 44. Raise out0_ready -> the edge delivers 33 and loads 44 (no bubble); cnt0 +1.
- Slot 0 stalled FULL with 55 while 66 is sent to out1 with out1_ready=1 -> 66 delivered the next cycle, out0_data stays 55, cnt1 +1, cnt0 unchanged.
- Streaming 8 consecutive words to out1 with out1_ready held 1 -> in_ready stays 1, one word per cycle, cnt1 advances by 8. Also preload cnt1 near wrap (CNT_W=4, 15 transfers, then 1 more) -> cnt1 reads 0.
- Assert reset while both slots are FULL with 77 and 88 and readys=0 -> both valids 0 and data 0 next edge. Raise readys during reset -> no counter change.
